// File: rtl/sad_best_mv_select.sv
// Best-MV selector: tracks per-partition minimum SAD and its MV across a search,
// then streams the 105 (SAD, MV) results over a valid/ready interface.
module sad_best_mv_select #(
    parameter int unsigned NUM_CAND = 1024,
    parameter int unsigned MV_W     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            sad_valid,
    input  logic [MV_W-1:0] sad_mv_x,
    input  logic [MV_W-1:0] sad_mv_y,
    input  logic [415:0]    sad4x8,
    input  logic [415:0]    sad8x4,
    input  logic [223:0]    sad8x8,
    input  logic [119:0]    sad8x16,
    input  logic [119:0]    sad16x8,
    input  logic [63:0]     sad16x16,
    input  logic [33:0]     sad16x32,
    input  logic [33:0]     sad32x16,
    input  logic [17:0]     sad32x32,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [6:0]      res_idx,
    output logic [17:0]     res_sad,
    output logic [MV_W-1:0] res_mv_x,
    output logic [MV_W-1:0] res_mv_y,
    output logic            res_last
);

    localparam int unsigned CntW    = $clog2(NUM_CAND + 1);
    localparam int unsigned NumPart = 105;
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_CAND - 1);
    localparam logic [6:0]      LastIdx = 7'd104;

    typedef enum logic [1:0] {StIdle, StSearch, StOutput} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [6:0]        ptr_q, ptr_d, sel_ptr;
    logic              res_valid_q, res_valid_d, res_last_q, res_last_d;
    logic [6:0]        res_idx_q, res_idx_d;
    logic [17:0]       res_sad_q, res_sad_d;
    logic [MV_W-1:0]   res_mv_x_q, res_mv_x_d, res_mv_y_q, res_mv_y_d;

    logic [17:0]       cand_sad [NumPart];
    logic [17:0]       tbl_sad  [NumPart];
    logic [MV_W-1:0]   tbl_mv_x [NumPart];
    logic [MV_W-1:0]   tbl_mv_y [NumPart];

    // Flatten the lane buses onto the partition index map, zero-extended to 18b.
    always_comb begin
        for (int i = 0; i < NumPart; i++) cand_sad[i] = '0;
        for (int k = 0; k < 32; k++) begin
            cand_sad[k]      = 18'(sad4x8[13*k +: 13]);
            cand_sad[32 + k] = 18'(sad8x4[13*k +: 13]);
        end
        for (int k = 0; k < 16; k++) cand_sad[64 + k] = 18'(sad8x8[14*k +: 14]);
        for (int k = 0; k < 8; k++) begin
            cand_sad[80 + k] = 18'(sad8x16[15*k +: 15]);
            cand_sad[88 + k] = 18'(sad16x8[15*k +: 15]);
        end
        for (int k = 0; k < 4; k++) cand_sad[96 + k] = 18'(sad16x16[16*k +: 16]);
        for (int k = 0; k < 2; k++) begin
            cand_sad[100 + k] = 18'(sad16x32[17*k +: 17]);
            cand_sad[102 + k] = 18'(sad32x16[17*k +: 17]);
        end
        cand_sad[104] = sad32x32;
    end

    // Strict less-than keeps the earlier MV on ties; first candidate loads unconditionally.
    always_ff @(posedge clk) begin
        if (state_q == StSearch && sad_valid) begin
            for (int i = 0; i < NumPart; i++) begin
                if (cnt_q == '0 || cand_sad[i] < tbl_sad[i]) begin
                    tbl_sad[i]  <= cand_sad[i];
                    tbl_mv_x[i] <= sad_mv_x;
                    tbl_mv_y[i] <= sad_mv_y;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_idx_q   <= '0;
            res_sad_q   <= '0;
            res_mv_x_q  <= '0;
            res_mv_y_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            res_idx_q   <= res_idx_d;
            res_sad_q   <= res_sad_d;
            res_mv_x_q  <= res_mv_x_d;
            res_mv_y_q  <= res_mv_y_d;
        end
    end

    // Entry to present next: current ptr on the first beat, ptr+1 after a handshake.
    assign sel_ptr = (res_valid_q && !res_last_q) ? ptr_q + 7'd1 : ptr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        res_idx_d   = res_idx_q;
        res_sad_d   = res_sad_q;
        res_mv_x_d  = res_mv_x_q;
        res_mv_y_d  = res_mv_y_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSearch;
                    cnt_d   = '0;
                end
            end
            StSearch: begin
                if (sad_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_d     = StOutput;
                        ptr_d       = '0;
                        res_valid_d = 1'b0;
                        res_last_d  = 1'b0;
                    end
                end
            end
            StOutput: begin
                if (res_valid_q && res_ready && res_last_q) begin
                    state_d     = StIdle;
                    ptr_d       = '0;
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                end else if (!res_valid_q || res_ready) begin
                    ptr_d       = sel_ptr;
                    res_valid_d = 1'b1;
                    res_last_d  = (sel_ptr == LastIdx);
                    res_idx_d   = sel_ptr;
                    res_sad_d   = tbl_sad[sel_ptr];
                    res_mv_x_d  = tbl_mv_x[sel_ptr];
                    res_mv_y_d  = tbl_mv_y[sel_ptr];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    assign res_valid = res_valid_q;
    assign res_last  = res_last_q;
    assign res_idx   = res_idx_q;
    assign res_sad   = res_sad_q;
    assign res_mv_x  = res_mv_x_q;
    assign res_mv_y  = res_mv_y_q;

endmodule
